tdm_mux8: RTL and testbench
===========================

TDM_MUX8 -- requirements
Module: tdm_mux8

Interface
REQ-001 The block SHALL have a single clock, clk, with all state updated on its rising edge.
REQ-002 Reset SHALL be rst, asynchronous, active-high.
REQ-003 Port list SHALL be, one per line, in this order:
- clk  input  1  system clock
- rst  input  1  async active-high reset
- en  input  1  grant enable; 0 freezes output scheduling
- din  input  8  data bit per lane, lane i on din[i]
- req  input  8  lane i offers din[i] this cycle
- ack  output  8  lane i can accept; combinational, ack[i] = ~pend[i]
- dout  output  1  serialized data bit, registered
- sel  output  3  lane index of dout, as {s2,s1,s0} for the downstream 1-to-8 demux, registered
- vout  output  1  dout/sel valid this cycle, registered

Function
REQ-004 Each lane i SHALL have a 1-bit buffer buf[i] and a pending flag pend[i].
REQ-005 Capture SHALL occur at the clock edge where req[i] & ack[i], setting buf[i] <= din[i] and pend[i] <= 1; req[i] while ack[i]=0 SHALL be ignored with no capture and no error.
REQ-006 A round-robin pointer ptr[2:0] SHALL select the grant: the first lane with pend=1, scanning ptr, ptr+1, ... mod 8.
REQ-007 On an edge with en=1 and any pend=1, granting lane g, the block SHALL set dout <= buf[g], sel <= g, vout <= 1, pend[g] <= 0, ptr <= g+1 mod 8 (7 wraps to 0).
REQ-008 On an edge with en=0 or no pend set, the block SHALL set vout <= 0, hold dout, sel and ptr, and leave all pend flags unchanged.
REQ-009 At most one lane SHALL be granted per edge, giving a peak throughput of one bit per clock.
REQ-010 A lane captured at an edge SHALL NOT be grant-eligible until the following edge; grant eligibility uses registered pend only.
REQ-011 A lane granted at an edge has ack=0 in that cycle, so it SHALL NOT be refilled at that edge; it SHALL be refillable from the next cycle.
REQ-012 Capture on one lane and grant on a different lane at the same edge SHALL both take effect.
REQ-013 Capture SHALL continue while en=0; pending data SHALL be held indefinitely with no loss.
REQ-014 Latency: with req[i] asserted in cycle N and the lane empty and uncontested, vout=1 with sel=i SHALL appear in cycle N+2, i.e. after the second rising edge.
REQ-015 With all 8 lanes pending and ptr=p, grants SHALL occur in order p, p+1, ..., p+7 mod 8 over 8 consecutive cycles.

Reset
REQ-016 While rst=1, outputs SHALL be pend=0, buf=0, ptr=0, dout=0, sel=0, vout=0, and ack=8'hFF.
REQ-017 Reset asserted mid-operation SHALL discard all pending data immediately, with no further vout pulses for that data.
REQ-018 The first edge after rst deasserts SHALL operate normally, with no dead cycle.

Structure
REQ-019 Constants LANES=8 and SEL_W=3 SHALL live in a shared package mux_pkg.
REQ-020 The round-robin search SHALL be a combinational sub-module rr_pick8 (inputs pend[7:0] and ptr[2:0]; outputs any and idx[2:0]), instantiated once.
REQ-021 No other sub-modules SHALL be used.

Verification
REQ-022 Reset: assert rst mid-stream with 3 lanes pending -> vout=0, ack=8'hFF in the same cycle, and no vout after release.
REQ-023 Single lane: req=8'h20, din=8'h20 for one cycle at N -> cycle N+2 shows vout=1, sel=5, dout=1; cycle N+3 shows vout=0.
REQ-024 Fairness: preload all 8 lanes (din=8'hA5) with en=0, then set en=1 and ptr=0 -> sel sequence 0..7 and dout sequence 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles.
REQ-025 Wrap and refill: lane 7 granted (ptr becomes 0) while lane 7 req is held high -> ack[7]=0 in the grant cycle, recapture one cycle later, and lanes 0..6 served before lane 7 again.
REQ-026 Backpressure: req[3] held high and en=0 for 10 cycles -> exactly one capture, ack[3]=0 thereafter, and a single vout with sel=3 after en=1.
REQ-027 Concurrency: lane 2 captured at the same edge as lane 6 is granted -> both take effect, and lane 2 is output on the next cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the 8-lane TDM serializer.
package mux_pkg;
    localparam int LANES = 8;
    localparam int SEL_W = 3;
endpackage

// File: rtl/rr_pick8.sv
// Round-robin search: first pending lane at or after ptr, wrapping mod 8.
module rr_pick8
    import mux_pkg::*;
(
    input  logic [LANES-1:0] pend,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest pending lane wins.
    always_comb begin
        any  = |pend;
        idx  = '0;
        cand = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            cand = ptr + k[SEL_W-1:0];
            if (pend[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/tdm_mux8.sv
// 8-lane to 1-bit time-division serializer with per-lane 1-bit buffers and
// round-robin grant; dout/sel/vout are registered, ack is combinational.
module tdm_mux8
    import mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LANES-1:0] din,
    input  logic [LANES-1:0] req,
    output logic [LANES-1:0] ack,
    output logic             dout,
    output logic [SEL_W-1:0] sel,
    output logic             vout
);

    logic [LANES-1:0] pend;
    logic [LANES-1:0] dbuf;
    logic [SEL_W-1:0] ptr;
    logic             any;
    logic [SEL_W-1:0] idx;
    logic             grant;
    logic [LANES-1:0] gnt_mask;
    logic [LANES-1:0] cap;

    rr_pick8 u_pick (
        .pend (pend),
        .ptr  (ptr),
        .any  (any),
        .idx  (idx)
    );

    assign ack = ~pend;

    // Capture only lands on empty lanes, so it never collides with the grant.
    always_comb begin
        grant    = en & any;
        cap      = req & ack;
        gnt_mask = '0;
        if (grant) begin
            gnt_mask[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            dbuf <= '0;
            ptr  <= '0;
            dout <= 1'b0;
            sel  <= '0;
            vout <= 1'b0;
        end else begin
            pend <= (pend & ~gnt_mask) | cap;
            dbuf <= (dbuf & ~cap) | (din & cap);
            if (grant) begin
                dout <= dbuf[idx];
                sel  <= idx;
                vout <= 1'b1;
                ptr  <= idx + 3'd1;
            end else begin
                vout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux8.sv
// Scoreboard bench for tdm_mux8: expected {sel,dout} pushed at stimulus time,
// popped by a monitor whenever vout is seen.
module tb_tdm_mux8;
    import mux_pkg::*;

    logic             clk;
    logic             rst;
    logic             en;
    logic [LANES-1:0] din;
    logic [LANES-1:0] req;
    logic [LANES-1:0] ack;
    logic             dout;
    logic [SEL_W-1:0] sel;
    logic             vout;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb_q[$];

    tdm_mux8 dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din),
        .req  (req),
        .ack  (ack),
        .dout (dout),
        .sel  (sel),
        .vout (vout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int lane, input logic bitv);
        sb_q.push_back({3'(lane), bitv});
    endtask

    always @(negedge clk) begin
        if (!rst && vout) begin
            if (sb_q.size() == 0) begin
                chk("sb_spurious", 32'(vout), 32'd0);
            end else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                chk("sb_sel", 32'(sel), 32'(e[3:1]));
                chk("sb_dout", 32'(dout), 32'(e[0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] pat;
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        req = '0;

        // reset state
        #1;
        chk("rst_vout", 32'(vout), 32'd0);
        chk("rst_ack",  32'(ack),  32'hFF);
        chk("rst_sel",  32'(sel),  32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        tick();

        // single lane, first cycle after reset release
        tick();
        rst = 1'b0; en = 1'b1; req = 8'h20; din = 8'h20;
        push_exp(5, 1'b1);
        @(negedge clk); chk("lat_n", 32'(vout), 32'd0);
        tick(); req = '0; din = '0;
        @(negedge clk); chk("lat_n1", 32'(vout), 32'd0);
        tick();
        @(negedge clk); chk("lat_n2", 32'(vout), 32'd1);
        tick();
        @(negedge clk); chk("lat_n3", 32'(vout), 32'd0);

        // backpressure: req[3] held with en=0 for 10 cycles
        tick(); en = 1'b0; req = 8'h08; din = 8'h08;
        @(negedge clk); chk("bp_ack0", 32'(ack[3]), 32'd1);
        for (int i = 1; i < 10; i++) begin
            tick();
            @(negedge clk);
            chk("bp_ack", 32'(ack[3]), 32'd0);
            chk("bp_hold", 32'(vout), 32'd0);
        end
        push_exp(3, 1'b1);
        tick(); req = '0; din = '0; en = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vout) n++;
            tick();
        end
        chk("bp_once", 32'(n), 32'd1);

        // concurrency: lane 2 captured while lane 6 granted (ptr=4)
        en = 1'b0; req = 8'h40; din = 8'h40;
        @(negedge clk);
        tick(); en = 1'b1; req = 8'h04; din = 8'h00;
        push_exp(6, 1'b1);
        push_exp(2, 1'b0);
        @(negedge clk); chk("cc_pre", 32'(vout), 32'd0);
        tick(); req = '0;
        @(negedge clk);
        chk("cc_a", 32'(vout), 32'd1);
        chk("cc_ack2", 32'(ack[2]), 32'd0);
        tick();
        @(negedge clk); chk("cc_b", 32'(vout), 32'd1);
        tick();
        @(negedge clk); chk("cc_end", 32'(vout), 32'd0);

        // reset mid-stream with lanes 1,4,6 still pending (ptr=3)
        tick(); req = 8'h5A; din = 8'h5A;
        push_exp(3, 1'b1);
        @(negedge clk);
        tick(); req = '0; din = '0;
        tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_vout", 32'(vout), 32'd0);
        chk("mid_ack",  32'(ack),  32'hFF);
        chk("mid_dout", 32'(dout), 32'd0);
        tick(); tick(); rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (vout) n++;
            tick();
        end
        chk("mid_novout", 32'(n), 32'd0);

        // fairness: preload all lanes with en=0, ptr=0
        en = 1'b0; req = 8'hFF; din = 8'hA5;
        tick(); req = '0; din = '0;
        @(negedge clk); chk("fair_full", 32'(ack), 32'h00);
        tick(); en = 1'b1;
        pat = 8'hA5;
        for (int i = 0; i < LANES; i++) push_exp(i, pat[i]);
        for (int i = 0; i < LANES; i++) begin
            tick();
            @(negedge clk); chk("fair_v", 32'(vout), 32'd1);
        end
        tick();
        @(negedge clk); chk("fair_end", 32'(vout), 32'd0);

        // wrap and refill: req held high across lane 7 grant (ptr=0)
        tick(); en = 1'b0; req = 8'hFF; din = 8'h3C;
        tick(); en = 1'b1;
        pat = 8'h3C;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < LANES; i++) push_exp(i, pat[i]);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 16) begin
                en = 1'b0; req = '0;
            end
            @(negedge clk);
            chk("wr_v", 32'(vout), 32'd1);
            if (c == 7) chk("wr_ack_grant", 32'(ack[7]), 32'd0);
            if (c == 8) chk("wr_ack_free",  32'(ack[7]), 32'd1);
            if (c == 9) chk("wr_recap",     32'(ack[7]), 32'd0);
        end
        tick();
        @(negedge clk); chk("wr_end", 32'(vout), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
